alu_req_sequencer: RTL and testbench
====================================

// Module: alu_req_sequencer
//
// PURPOSE
// - Shares one alu_main instance (4-bit add/sub/compare/AND) between NREQ requesters.
// - Round-robin arbitration; each requester uses a valid/ready request handshake.
// - Drives select0/select1/bit1/bit2 to the external ALU for one EXEC cycle.
// - Selects the result matching the opcode and returns it with the winner's ID.
// - Sits between client blocks and the shared alu_main in the datapath top.
//
// PARAMETERS
// - NREQ  default 2  number of requesters (2..4)
// - W     default 4  operand width; must match alu_main bit1/bit2
//
// PORTS
// - clk          in   1        single clock, rising edge
// - rst_n        in   1        asynchronous active-low reset
// - req_valid    in   NREQ     request pending, one bit per requester
// - req_ready    out  NREQ     request accepted this cycle (one-hot or zero)
// - req_op       in   2*NREQ   opcode per requester: 00 add, 01 sub, 10 cmp, 11 AND
// - req_a        in   W*NREQ   operand A per requester
// - req_b        in   W*NREQ   operand B per requester
// - alu_select0  out  1        to alu_main select0 (= op[0])
// - alu_select1  out  1        to alu_main select1 (= op[1])
// - alu_bit1     out  W        to alu_main bit1
// - alu_bit2     out  W        to alu_main bit2
// - alu_result1  in   W+1      from alu_main, sum
// - alu_result2  in   W+1      from alu_main, difference
// - alu_result4  in   W+1      from alu_main, AND
// - alu_eq       in   1        from alu_main equal
// - alu_gt       in   1        from alu_main greater
// - alu_lt       in   1        from alu_main lesser
// - resp_valid   out  1        response available
// - resp_ready   in   1        consumer accepts the response
// - resp_data    out  W+1      selected result
// - resp_id      out  clog2(NREQ)  index of the serviced requester
// - busy         out  1        state != IDLE
//
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - state=IDLE; req_ready=0, resp_valid=0, resp_data=0, resp_id=0, busy=0.
//   - alu_* outputs = 0; rr pointer = 0 (requester 0 has top priority).
// - FSM IDLE -> EXEC -> RESP -> IDLE:
//   - IDLE:
//     - If any req_valid is set, grant the first set bit at or after the rr pointer.
//     - Assert req_ready[g] combinationally in the same cycle.
//     - Capture op/a/b/g into registers and go to EXEC.
//     - If no req_valid is set, stay in IDLE.
//   - EXEC (one cycle):
//     - alu_select0/1, alu_bit1/2 come from the captured registers and stay stable.
//     - At the end of the cycle, capture resp_data from the ALU inputs:
//       - 00 -> alu_result1; 01 -> alu_result2; 11 -> alu_result4.
//       - 10 -> {2'b00, alu_lt, alu_gt, alu_eq}, zero-extended to W+1.
//     - resp_id=g; go to RESP.
//   - RESP:
//     - resp_valid=1; resp_data and resp_id are held stable until resp_ready=1.
//     - On resp_valid&&resp_ready: rr pointer = (g+1) mod NREQ; go to IDLE.
// - Latency: accept in cycle N, resp_valid in cycle N+2.
// - Throughput: at most one operation per 3 cycles.
// - alu_* outputs hold their last values outside EXEC (no toggling in IDLE).
// - req_ready is only ever asserted in IDLE and never for more than one requester.
// - Requests that lose arbitration must keep req_valid and their operands stable.
// - The rr pointer only advances on response completion.
// - A stalled RESP (resp_ready low) blocks all new grants. No timeout.
// - Reset mid-EXEC/RESP: return to IDLE immediately and drop the in-flight operation.
//   - No response is issued for it; the requester must re-request.
// - Arithmetic (overflow, borrow encoding) is defined by alu_main.
//   - This block passes W+1 bits through unmodified.
//
// STRUCTURE
// - Shared package alu_pkg:
//   - ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_CMP=2'b10, ALU_AND=2'b11.
//   - State encodings S_IDLE/S_EXEC/S_RESP.
// - Sub-module alu_rr_arbiter (NREQ): req vector + pointer -> one-hot grant + index.
// - The FSM, operand registers and result mux live in this module.
//
// TESTING
// - Reset, then a single add on req 0, a=0110 b=1100:
//   - req_ready[0] pulses; resp_valid 2 cycles later.
//   - resp_data=10010, resp_id=0.
// - Sub on req 1, a=1010 b=0010 -> resp_data=01000, resp_id=1.
// - Cmp a=1011 b=1111 -> resp_data=00100 (lt).
// - AND a=1111 b=0000 -> resp_data=00000.
// - Arbitration: both requesters hold valid continuously, resp_ready=1 -> grants 0,1,0,1.
// - Backpressure: resp_ready=0 for 5 cycles in RESP:
//   - resp_data stays stable and req_ready stays 0.
//   - On release, the next grant goes to the other requester.
// - Reset: assert rst_n=0 during EXEC:
//   - All outputs are 0 immediately, state=IDLE.
//   - The first grant after reset goes to requester 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode and sequencer state encodings for the alu_main request sequencer.
package alu_pkg;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_CMP = 2'b10;
    localparam logic [1:0] ALU_AND = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_rr_arbiter.sv
// Round-robin pick: first set request bit at or after the pointer, wrapping to bit 0.
module alu_rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]          req_i,
    input  logic [$clog2(NREQ)-1:0]  ptr_i,
    output logic [NREQ-1:0]          grant_o,
    output logic [$clog2(NREQ)-1:0]  idx_o,
    output logic                     any_o
);

    localparam int IW = $clog2(NREQ);

    logic found;

    // First pass covers indices >= pointer; second pass handles the wrap-around.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_i[i] && (IW'(i) >= ptr_i)) begin
                found      = 1'b1;
                grant_o[i] = 1'b1;
                idx_o      = IW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_i[i]) begin
                found      = 1'b1;
                grant_o[i] = 1'b1;
                idx_o      = IW'(i);
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/alu_req_sequencer.sv
// Time-shares one external alu_main between NREQ requesters: arbitrate, drive the ALU
// for one EXEC cycle, then hold the selected result until the consumer takes it.
module alu_req_sequencer
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int W    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [2*NREQ-1:0]        req_op,
    input  logic [W*NREQ-1:0]        req_a,
    input  logic [W*NREQ-1:0]        req_b,
    output logic                     alu_select0,
    output logic                     alu_select1,
    output logic [W-1:0]             alu_bit1,
    output logic [W-1:0]             alu_bit2,
    input  logic [W:0]               alu_result1,
    input  logic [W:0]               alu_result2,
    input  logic [W:0]               alu_result4,
    input  logic                     alu_eq,
    input  logic                     alu_gt,
    input  logic                     alu_lt,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [W:0]               resp_data,
    output logic [$clog2(NREQ)-1:0]  resp_id,
    output logic                     busy,
    output state_e                   dbg_state_o
);

    localparam int IW = $clog2(NREQ);

    // Handshakes: a transfer happens on a rising edge where valid && ready; valid never
    // depends on ready, losers keep valid and payload stable, resp payload holds while stalled.

    state_e          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic [IW-1:0]   g_q, g_d, ptr_q, ptr_d, ptr_nxt;
    logic [W:0]      resp_data_q, resp_data_d;
    logic [IW-1:0]   resp_id_q, resp_id_d;

    logic [NREQ-1:0] grant;
    logic [IW-1:0]   gidx;
    logic            any_req;
    logic [1:0]      op_sel;
    logic [W-1:0]    a_sel, b_sel;
    logic [W:0]      result_mux;

    alu_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (gidx),
        .any_o   (any_req)
    );

    always_comb begin
        op_sel = '0;
        a_sel  = '0;
        b_sel  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gidx == IW'(i)) begin
                op_sel = req_op[2*i +: 2];
                a_sel  = req_a[W*i +: W];
                b_sel  = req_b[W*i +: W];
            end
        end
    end

    always_comb begin
        case (op_q)
            ALU_ADD: result_mux = alu_result1;
            ALU_SUB: result_mux = alu_result2;
            ALU_AND: result_mux = alu_result4;
            default: result_mux = {{(W-2){1'b0}}, alu_lt, alu_gt, alu_eq};
        endcase
    end

    assign ptr_nxt = (g_q == IW'(NREQ-1)) ? '0 : g_q + IW'(1);

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        g_d         = g_q;
        ptr_d       = ptr_q;
        resp_data_d = resp_data_q;
        resp_id_d   = resp_id_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    op_d    = op_sel;
                    a_d     = a_sel;
                    b_d     = b_sel;
                    g_d     = gidx;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                resp_data_d = result_mux;
                resp_id_d   = g_q;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) begin
                    ptr_d   = ptr_nxt;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            g_q         <= '0;
            ptr_q       <= '0;
            resp_data_q <= '0;
            resp_id_q   <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            g_q         <= g_d;
            ptr_q       <= ptr_d;
            resp_data_q <= resp_data_d;
            resp_id_q   <= resp_id_d;
        end
    end

    // Gated by rst_n so no grant is visible while reset is held with requests pending.
    assign req_ready   = (state_q == S_IDLE && rst_n) ? grant : '0;
    assign alu_select0 = op_q[0];
    assign alu_select1 = op_q[1];
    assign alu_bit1    = a_q;
    assign alu_bit2    = b_q;
    assign resp_valid  = (state_q == S_RESP);
    assign resp_data   = resp_data_q;
    assign resp_id     = resp_id_q;
    assign busy        = (state_q != S_IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_req_sequencer.sv
// Bench for alu_req_sequencer: transaction-level model plus directed and random traffic.
module tb_alu_req_sequencer;
    import alu_pkg::*;

    localparam int NREQ = 2;
    localparam int W    = 4;
    localparam int IW   = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NREQ-1:0]   req_valid, req_ready;
    logic [2*NREQ-1:0] req_op;
    logic [W*NREQ-1:0] req_a, req_b;
    logic              alu_select0, alu_select1;
    logic [W-1:0]      alu_bit1, alu_bit2;
    logic [W:0]        alu_result1, alu_result2, alu_result4;
    logic              alu_eq, alu_gt, alu_lt;
    logic              resp_valid, resp_ready;
    logic [W:0]        resp_data;
    logic [IW-1:0]     resp_id;
    logic              busy;
    state_e            dbg_state;

    logic [1:0]   op_arr [NREQ];
    logic [W-1:0] a_arr  [NREQ];
    logic [W-1:0] b_arr  [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_op[2*i +: 2] = op_arr[i];
            req_a[W*i +: W]  = a_arr[i];
            req_b[W*i +: W]  = b_arr[i];
        end
    end

    // Stand-in for alu_main.
    always_comb begin
        alu_result1 = {1'b0, alu_bit1} + {1'b0, alu_bit2};
        alu_result2 = {1'b0, alu_bit1} - {1'b0, alu_bit2};
        alu_result4 = {1'b0, alu_bit1 & alu_bit2};
        alu_eq      = (alu_bit1 == alu_bit2);
        alu_gt      = (alu_bit1 > alu_bit2);
        alu_lt      = (alu_bit1 < alu_bit2);
    end

    alu_req_sequencer #(.NREQ(NREQ), .W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .alu_select0 (alu_select0),
        .alu_select1 (alu_select1),
        .alu_bit1    (alu_bit1),
        .alu_bit2    (alu_bit2),
        .alu_result1 (alu_result1),
        .alu_result2 (alu_result2),
        .alu_result4 (alu_result4),
        .alu_eq      (alu_eq),
        .alu_gt      (alu_gt),
        .alu_lt      (alu_lt),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .resp_id     (resp_id),
        .busy        (busy),
        .dbg_state_o (dbg_state)
    );

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, exp);
        end
    endfunction

    function automatic logic [W:0] ref_result(input logic [1:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        case (op)
            2'b00:   return {1'b0, a} + {1'b0, b};
            2'b01:   return {1'b0, a} - {1'b0, b};
            2'b10:   return {2'b00, (a < b), (a > b), (a == b)};
            default: return {1'b0, a & b};
        endcase
    endfunction

    // Model state: one outstanding transaction, its accept cycle, rr pointer, last ALU drive.
    logic [IW+W:0]   exp_q[$];
    bit              pending;
    int              cyc, acc_cyc, ptr_m, g_m;
    logic [1:0]      alu_op_m;
    logic [W-1:0]    alu_a_m, alu_b_m;
    logic [NREQ-1:0] exp_rdy;
    bit              exp_rv;

    logic [NREQ-1:0] seen_ready;
    logic            seen_rv, seen_busy;
    logic [W:0]      seen_rdata;
    logic [IW-1:0]   seen_rid;

    always @(negedge clk) begin
        seen_ready = req_ready;
        seen_rv    = resp_valid;
        seen_busy  = busy;
        seen_rdata = resp_data;
        seen_rid   = resp_id;
        if (!rst_n) begin
            chk("rst_req_ready", 32'(req_ready), 0);
            chk("rst_resp_valid", 32'(resp_valid), 0);
            chk("rst_resp_data", 32'(resp_data), 0);
            chk("rst_resp_id", 32'(resp_id), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_alu", {alu_select1, alu_select0, alu_bit1, alu_bit2}, 0);
            pending  = 1'b0;
            ptr_m    = 0;
            alu_op_m = '0;
            alu_a_m  = '0;
            alu_b_m  = '0;
            exp_q.delete();
        end else begin
            exp_rdy = '0;
            g_m     = -1;
            if (!pending) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (g_m < 0 && req_valid[(ptr_m + k) % NREQ]) g_m = (ptr_m + k) % NREQ;
                end
                if (g_m >= 0) exp_rdy[g_m] = 1'b1;
            end
            exp_rv = pending && (cyc - acc_cyc >= 2);
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("busy", 32'(busy), 32'(pending));
            chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
            chk("alu_drive", {alu_select1, alu_select0, alu_bit1, alu_bit2},
                {alu_op_m, alu_a_m, alu_b_m});
            if (exp_rv && exp_q.size() > 0) begin
                chk("resp_data", 32'(resp_data), 32'(exp_q[0][W:0]));
                chk("resp_id", 32'(resp_id), 32'(exp_q[0][IW+W:W+1]));
                if (resp_ready) begin
                    ptr_m   = (int'(exp_q[0][IW+W:W+1]) + 1) % NREQ;
                    pending = 1'b0;
                    void'(exp_q.pop_front());
                end
            end
            if (g_m >= 0) begin
                pending  = 1'b1;
                acc_cyc  = cyc;
                exp_q.push_back({IW'(g_m), ref_result(op_arr[g_m], a_arr[g_m], b_arr[g_m])});
                alu_op_m = op_arr[g_m];
                alu_a_m  = a_arr[g_m];
                alu_b_m  = b_arr[g_m];
            end
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input int i, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W:0] exp_d, input string nm);
        int n;
        int lat;
        op_arr[i] = op;
        a_arr[i]  = a;
        b_arr[i]  = b;
        req_valid[i] = 1'b1;
        resp_ready   = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!seen_ready[i] && n < 20);
        chk({nm, "_accept"}, 32'(seen_ready), 32'(1 << i));
        req_valid[i] = 1'b0;
        lat = 0;
        do begin tick(); lat++; end while (!seen_rv && lat < 20);
        chk({nm, "_latency"}, lat, 2);
        chk({nm, "_data"}, 32'(seen_rdata), 32'(exp_d));
        chk({nm, "_id"}, 32'(seen_rid), i);
    endtask

    initial begin
        int n;
        int g1;
        int got[$];
        logic [W:0] d0;

        req_valid  = '0;
        resp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            op_arr[i] = '0;
            a_arr[i]  = '0;
            b_arr[i]  = '0;
        end
        cyc = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        run_op(0, ALU_ADD, 4'b0110, 4'b1100, 5'b10010, "add");
        run_op(1, ALU_SUB, 4'b1010, 4'b0010, 5'b01000, "sub");
        run_op(0, ALU_CMP, 4'b1011, 4'b1111, 5'b00100, "cmp");
        run_op(1, ALU_AND, 4'b1111, 4'b0000, 5'b00000, "and");

        // Both requesters hold valid: grants must alternate starting at 0.
        op_arr[0] = ALU_ADD; a_arr[0] = 4'd3; b_arr[0] = 4'd4;
        op_arr[1] = ALU_SUB; a_arr[1] = 4'd9; b_arr[1] = 4'd2;
        req_valid  = 2'b11;
        resp_ready = 1'b1;
        n = 0;
        while (got.size() < 4 && n < 60) begin
            tick();
            n++;
            if (seen_ready != '0) got.push_back(seen_ready[1] ? 1 : 0);
            if (got.size() == 4) req_valid = '0;
        end
        chk("arb_count", got.size(), 4);
        for (int k = 0; k < got.size(); k++) chk($sformatf("arb_grant%0d", k), got[k], k % 2);
        req_valid = '0;
        repeat (4) tick();

        // Stalled response: data held, no grants, then the other requester wins.
        resp_ready = 1'b0;
        req_valid  = 2'b11;
        n = 0;
        do begin tick(); n++; end while (seen_ready == '0 && n < 20);
        g1 = seen_ready[1] ? 1 : 0;
        chk("bp_first_grant", 32'(seen_ready), 32'b01);
        n = 0;
        do begin tick(); n++; end while (!seen_rv && n < 20);
        d0 = seen_rdata;
        chk("bp_data", 32'(d0), 32'd7);
        repeat (5) begin
            tick();
            chk("bp_data_stable", 32'(seen_rdata), 32'(d0));
            chk("bp_no_grant", 32'(seen_ready), 0);
            chk("bp_valid_held", 32'(seen_rv), 1);
        end
        resp_ready = 1'b1;
        n = 0;
        do begin tick(); n++; end while (seen_ready == '0 && n < 20);
        chk("bp_next_grant", 32'(seen_ready), 32'(1 << (1 - g1)));
        req_valid = '0;
        repeat (4) tick();

        // Reset while EXEC is in flight.
        op_arr[1] = ALU_AND; a_arr[1] = 4'hf; b_arr[1] = 4'h5;
        req_valid = 2'b10;
        n = 0;
        do begin tick(); n++; end while (!seen_ready[1] && n < 20);
        chk("rst_exec_accept", 32'(seen_ready), 32'b10);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async_ready", 32'(req_ready), 0);
        chk("rst_async_resp", {resp_valid, resp_data, resp_id}, 0);
        chk("rst_async_busy", 32'(busy), 0);
        chk("rst_async_alu", {alu_select1, alu_select0, alu_bit1, alu_bit2}, 0);
        chk("rst_async_state", 32'(dbg_state), 32'(S_IDLE));
        req_valid = 2'b11;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_grant", 32'(seen_ready), 32'b01);
        req_valid = '0;
        repeat (4) tick();

        // Random traffic; a request stays put until accepted.
        repeat (400) begin
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if ((req_valid[i] && seen_ready[i]) || (!req_valid[i] && $urandom_range(0, 3) == 0)) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    op_arr[i]    = 2'($urandom_range(0, 3));
                    a_arr[i]     = W'($urandom_range(0, 15));
                    b_arr[i]     = W'($urandom_range(0, 15));
                end
            end
            resp_ready = ($urandom_range(0, 3) != 0);
        end
        req_valid  = '0;
        resp_ready = 1'b1;
        repeat (6) tick();
        chk("final_idle", 32'(seen_busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
